// File: rtl/sd_cmd_phy.sv
// SD CMD-line transceiver: sends a 48-bit command frame, then receives and checks a
// 48- or 136-bit response. Define SD_CMD_CRC7_EN to build the CRC7 generator and checkers.
module sd_cmd_phy #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int NCC            = 8
) (
   input  logic         clk_SD,
   input  logic         reset_host,
   input  logic         cmd_start,
   input  logic [5:0]   cmd_index,
   input  logic [31:0]  cmd_argument,
   input  logic [1:0]   resp_type,
   output logic         busy,
   output logic         cmd_complete,
   output logic [127:0] response,
   output logic [5:0]   resp_index,
   output logic         timeout_error,
   output logic         crc_error,
   output logic         index_error,
   output logic         end_bit_error,
   output logic         CMD_PIN_OUT,
   output logic         IO_enable_pin,
   input  logic         CMD_PIN_IN
);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_START, RECV, GAP, DONE} state_t;

   // One counter serves every timed state, so it is sized for the longest of them.
   localparam int CNT_MAX = (TIMEOUT_CYCLES > 136) ?
                            ((TIMEOUT_CYCLES > NCC) ? TIMEOUT_CYCLES : NCC) :
                            ((NCC > 136) ? NCC : 136);
   localparam int CW = $clog2(CNT_MAX);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic [47:0]    tx_sr;
   logic [133:0]   rx_sr;
   logic [134:0]   rx_next;
   logic [5:0]     idx_q;
   logic [1:0]     type_q;
   logic [39:0]    tx_head;
   logic [6:0]     tx_crc;
   logic           accept, is_long, start_seen, wait_expired, rx_last, gap_done;

   assign accept       = (state_q == IDLE) && cmd_start;
   assign is_long      = (type_q == 2'd2);
   assign start_seen   = (state_q == WAIT_START) && !CMD_PIN_IN;
   assign wait_expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign gap_done     = (cnt_q == CW'(NCC - 1));
   assign rx_last      = (state_q == RECV) && (cnt_q == (is_long ? CW'(134) : CW'(46)));
   // Frame bits 134:0 with the bit now on the line in position 0; start bit is implied 0.
   assign rx_next      = {rx_sr, CMD_PIN_IN};
   assign tx_head      = {2'b01, cmd_index, cmd_argument};

`ifdef SD_CMD_CRC7_EN
   // CRC7 (x^7+x^3+1), MSB first; leading zeros leave a zero-seeded CRC untouched.
   function automatic logic [6:0] crc7(input logic [119:0] data);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 119; i >= 0; i--) begin
         fb = data[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   logic crc_hit;
   assign tx_crc  = crc7({80'd0, tx_head});
   assign crc_hit = is_long ? (crc7(rx_next[127:8]) != rx_next[7:1])
                            : ((type_q == 2'd1) && (crc7({80'd0, rx_next[47:8]}) != rx_next[7:1]));

   always_ff @(posedge clk_SD) begin
      if (reset_host)   crc_error <= 1'b0;
      else if (accept)  crc_error <= 1'b0;
      else if (rx_last) crc_error <= crc_hit;
   end
`else
   assign tx_crc    = 7'h00;
   assign crc_error = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_SD) begin
      if (reset_host) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (cmd_start) state_d = SEND;
         SEND:       if (cnt_q == CW'(47)) state_d = (type_q == 2'd0) ? GAP : WAIT_START;
         WAIT_START: if (!CMD_PIN_IN) state_d = RECV;
                     else if (wait_expired) state_d = DONE;
         RECV:       if (rx_last) state_d = DONE;
         GAP:        if (gap_done) state_d = DONE;
         DONE:       state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q != IDLE);
      cmd_complete  = (state_q == DONE);
      IO_enable_pin = (state_q == SEND);
      CMD_PIN_OUT   = (state_q == SEND) ? tx_sr[47] : 1'b1;
   end

   always_ff @(posedge clk_SD) begin
      if (reset_host) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         type_q        <= '0;
         response      <= '0;
         resp_index    <= '0;
         timeout_error <= 1'b0;
         index_error   <= 1'b0;
         end_bit_error <= 1'b0;
      end else begin
         cnt_q <= ((state_q == IDLE) || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
         if (accept) begin
            idx_q         <= cmd_index;
            type_q        <= resp_type;
            response      <= '0;
            resp_index    <= '0;
            timeout_error <= 1'b0;
            index_error   <= 1'b0;
            end_bit_error <= 1'b0;
         end
         if ((state_q == WAIT_START) && CMD_PIN_IN && wait_expired) timeout_error <= 1'b1;
         if (rx_last) begin
            end_bit_error <= ~rx_next[0];
            if (is_long) begin
               response    <= rx_next[127:0];
               resp_index  <= 6'h3F;
               index_error <= rx_next[134] | (rx_next[133:128] != 6'h3F);
            end else begin
               response    <= {96'd0, rx_next[39:8]};
               resp_index  <= rx_next[45:40];
               index_error <= rx_next[46] | ((type_q == 2'd1) && (rx_next[45:40] != idx_q));
            end
         end
      end
   end

   // NOTE: the shift registers carry no reset; each is loaded before any of its bits is used.
   always_ff @(posedge clk_SD) begin
      if (accept)                tx_sr <= {tx_head, tx_crc, 1'b1};
      else if (state_q == SEND)  tx_sr <= {tx_sr[46:0], 1'b1};
      if (start_seen)            rx_sr <= '0;
      else if (state_q == RECV)  rx_sr <= {rx_sr[132:0], CMD_PIN_IN};
   end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Self-checking bench for sd_cmd_phy: directed cases plus randomized commands and
// responses, compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_sd_cmd_phy;

   localparam int T     = 64;
   localparam int NCC_P = 8;
`ifdef SD_CMD_CRC7_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic         clk_SD = 1'b0;
   logic         reset_host, cmd_start, CMD_PIN_IN;
   logic [5:0]   cmd_index;
   logic [31:0]  cmd_argument;
   logic [1:0]   resp_type;
   logic         busy, cmd_complete, CMD_PIN_OUT, IO_enable_pin;
   logic [127:0] response;
   logic [5:0]   resp_index;
   logic         timeout_error, crc_error, index_error, end_bit_error;

   int total = 0;
   int bad   = 0;

   sd_cmd_phy #(.TIMEOUT_CYCLES(T), .NCC(NCC_P)) dut (
      .clk_SD(clk_SD), .reset_host(reset_host), .cmd_start(cmd_start),
      .cmd_index(cmd_index), .cmd_argument(cmd_argument), .resp_type(resp_type),
      .busy(busy), .cmd_complete(cmd_complete), .response(response),
      .resp_index(resp_index), .timeout_error(timeout_error), .crc_error(crc_error),
      .index_error(index_error), .end_bit_error(end_bit_error),
      .CMD_PIN_OUT(CMD_PIN_OUT), .IO_enable_pin(IO_enable_pin), .CMD_PIN_IN(CMD_PIN_IN)
   );

   always #5 clk_SD = ~clk_SD;

   // flags packed as {timeout, crc, index, end_bit}
   typedef struct {
      logic [47:0]  tx;
      bit           send_ok;
      bit           io_off;
      bit           done;
      int           done_cyc;
      logic [127:0] resp;
      logic [5:0]   ridx;
      logic [3:0]   flags;
      bit           post_ok;
   } obs_t;

   // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1 (0x89).
   function automatic logic [6:0] ref_crc(input logic [119:0] msg);
      logic [126:0] r;
      r = {msg, 7'd0};
      for (int i = 126; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [135:0] mk_r48(input logic [5:0] i, input logic [31:0] p);
      logic [39:0] h;
      h = {2'b00, i, p};
      return {88'd0, h, ref_crc({80'd0, h}), 1'b1};
   endfunction

   function automatic logic [135:0] mk_r2(input logic [119:0] p);
      return {2'b00, 6'h3F, p, ref_crc(p), 1'b1};
   endfunction

   function automatic obs_t ref_model(input logic [5:0] idx, input logic [31:0] arg,
                                      input logic [1:0] rt, input bit respond,
                                      input int gap, input logic [135:0] rf);
      obs_t e;
      logic [47:0] f;
      bit c;
      e.tx = {2'b01, idx, arg, (CRC_ON ? ref_crc({80'd0, 2'b01, idx, arg}) : 7'h00), 1'b1};
      e.send_ok = 1; e.io_off = 1; e.done = 1; e.post_ok = 1;
      e.resp = '0; e.ridx = '0; e.flags = 4'b0000;
      if (rt == 2'd0) begin
         e.done_cyc = 49 + NCC_P;
      end else if (!respond) begin
         e.done_cyc = 49 + T;
         e.flags    = 4'b1000;
      end else if (rt == 2'd2) begin
         e.done_cyc = 49 + gap + 136;
         e.resp     = rf[127:0];
         e.ridx     = 6'h3F;
         c          = CRC_ON && (ref_crc(rf[127:8]) != rf[7:1]);
         e.flags    = {1'b0, c, (rf[134] || rf[133:128] != 6'h3F), !rf[0]};
      end else begin
         f          = rf[47:0];
         e.done_cyc = 49 + gap + 48;
         e.resp     = {96'd0, f[39:8]};
         e.ridx     = f[45:40];
         c          = CRC_ON && (rt == 2'd1) && (ref_crc({80'd0, f[47:8]}) != f[7:1]);
         e.flags    = {1'b0, c, (f[46] || (rt == 2'd1 && f[45:40] != idx)), !f[0]};
      end
      return e;
   endfunction

   // Drives one command (accept at edge 0) and the card's reply; records what the DUT did.
   task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input bit respond, input int gap, input logic [135:0] rf,
                          output obs_t o);
      int n, s, limit;
      n = (rt == 2'd2) ? 136 : 48;
      s = 49 + gap;
      limit = 49 + T + 136 + NCC_P + 8;
      o.send_ok = 1; o.io_off = 0; o.done = 0; o.done_cyc = -1; o.tx = '0; o.post_ok = 0;
      @(negedge clk_SD);
      cmd_index = idx; cmd_argument = arg; resp_type = rt; cmd_start = 1'b1;
      @(posedge clk_SD);
      for (int c = 1; c <= 48; c++) begin
         @(negedge clk_SD);
         if (c == 1) begin
            cmd_index = 6'($urandom); cmd_argument = $urandom; resp_type = 2'($urandom);
         end
         o.tx[48-c] = CMD_PIN_OUT;
         if (!(IO_enable_pin && busy && !cmd_complete)) o.send_ok = 0;
         CMD_PIN_IN = 1'($urandom);
         cmd_start  = (c == 10);
      end
      for (int c = 49; c <= limit && !o.done; c++) begin
         @(negedge clk_SD);
         if (c == 49) o.io_off = !IO_enable_pin && busy;
         if (cmd_complete) begin
            o.done = 1; o.done_cyc = c;
         end else if (rt == 2'd0) begin
            CMD_PIN_IN = 1'($urandom);
         end else begin
            CMD_PIN_IN = (respond && c >= s && c < s + n) ? rf[n-1-(c-s)] : 1'b1;
         end
      end
      o.resp  = response;
      o.ridx  = resp_index;
      o.flags = {timeout_error, crc_error, index_error, end_bit_error};
      CMD_PIN_IN = 1'b1;
      if (o.done) begin
         cmd_start = 1'b1; resp_type = 2'($urandom); cmd_index = 6'($urandom);
         @(negedge clk_SD);
         cmd_start = 1'b0;
         o.post_ok = !busy && !cmd_complete && (response === o.resp) &&
                     ({timeout_error, crc_error, index_error, end_bit_error} === o.flags);
      end
   endtask

   task automatic test_reset();
      reset_host = 1'b1;
      repeat (2) @(posedge clk_SD);
      @(negedge clk_SD);
      total++;
      if ({busy, cmd_complete, IO_enable_pin, CMD_PIN_OUT} !== 4'b0001) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0001", {busy, cmd_complete, IO_enable_pin, CMD_PIN_OUT});
      end
      total++;
      if ({timeout_error, crc_error, index_error, end_bit_error} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags: got %b want 0000", {timeout_error, crc_error, index_error, end_bit_error});
      end
      total++;
      if ({response, resp_index} !== 134'd0) begin
         bad++; $display("FAIL reset_resp: got %h/%h want 0/0", response, resp_index);
      end
      reset_host = 1'b0;
   endtask

   task automatic test_cmd0();
      obs_t o;
      logic [47:0] want;
      want = CRC_ON ? 48'h40_00000000_95 : 48'h40_00000000_01;
      run_txn(6'd0, 32'd0, 2'd0, 1'b0, 0, '0, o);
      total++;
      if (o.tx !== want) begin bad++; $display("FAIL cmd0_tx: got %h want %h", o.tx, want); end
      total++;
      if (o.done_cyc !== 57) begin bad++; $display("FAIL cmd0_cycle: got %0d want 57", o.done_cyc); end
      total++;
      if ({o.send_ok, o.io_off, o.post_ok, o.flags} !== 7'b1110000) begin
         bad++; $display("FAIL cmd0_status: got %b want 1110000", {o.send_ok, o.io_off, o.post_ok, o.flags});
      end
   endtask

   task automatic test_r7();
      obs_t o;
      logic [47:0] want;
      want = CRC_ON ? 48'h48_000001AA_87 : 48'h48_000001AA_01;
      run_txn(6'd8, 32'h1AA, 2'd1, 1'b1, 5, mk_r48(6'd8, 32'h1AA), o);
      total++;
      if (o.tx !== want) begin bad++; $display("FAIL r7_tx: got %h want %h", o.tx, want); end
      total++;
      if (o.done_cyc !== 102) begin bad++; $display("FAIL r7_cycle: got %0d want 102", o.done_cyc); end
      total++;
      if ({o.resp, o.ridx} !== {128'h1AA, 6'd8}) begin
         bad++; $display("FAIL r7_resp: got %h idx %h want 1aa idx 08", o.resp, o.ridx);
      end
      total++;
      if ({o.flags, o.post_ok} !== 5'b00001) begin
         bad++; $display("FAIL r7_flags: got %b want 00001", {o.flags, o.post_ok});
      end
   endtask

   task automatic test_r7_bad();
      obs_t o;
      logic [135:0] rf;
      rf = mk_r48(6'd9, 32'h1AA);
      rf[3] = ~rf[3];
      run_txn(6'd8, 32'h1AA, 2'd1, 1'b1, 3, rf, o);
      total++;
      if (o.flags !== {1'b0, CRC_ON, 2'b10}) begin
         bad++; $display("FAIL r7_bad_flags: got %b want %b", o.flags, {1'b0, CRC_ON, 2'b10});
      end
      total++;
      if ({o.done, o.done_cyc, o.ridx} !== {1'b1, 32'd100, 6'd9}) begin
         bad++; $display("FAIL r7_bad_done: got %0d/%0d idx %h want 1/100 idx 09", o.done, o.done_cyc, o.ridx);
      end
   endtask

   task automatic test_r2();
      obs_t o;
      logic [135:0] rf;
      rf = mk_r2({$urandom, $urandom, $urandom, 24'($urandom)});
      run_txn(6'd2, 32'd0, 2'd2, 1'b1, 7, rf, o);
      total++;
      if ({o.resp, o.ridx, o.flags} !== {rf[127:0], 6'h3F, 4'b0000}) begin
         bad++; $display("FAIL r2_resp: got %h %h %b want %h 3f 0000", o.resp, o.ridx, o.flags, rf[127:0]);
      end
      total++;
      if (o.done_cyc !== 49 + 7 + 136) begin bad++; $display("FAIL r2_cycle: got %0d want 192", o.done_cyc); end
      rf[0] = 1'b0;
      run_txn(6'd2, 32'd0, 2'd2, 1'b1, 0, rf, o);
      total++;
      if ({o.flags, o.post_ok} !== 5'b00011) begin
         bad++; $display("FAIL r2_endbit: got %b want 00011", {o.flags, o.post_ok});
      end
   endtask

   task automatic test_timeout();
      obs_t o;
      run_txn(6'd17, 32'h5555_AAAA, 2'd1, 1'b0, 0, '0, o);
      total++;
      if (o.done_cyc !== 113) begin bad++; $display("FAIL timeout_cycle: got %0d want 113", o.done_cyc); end
      total++;
      if ({o.flags, o.resp} !== {4'b1000, 128'd0}) begin
         bad++; $display("FAIL timeout_flags: got %b resp %h want 1000 resp 0", o.flags, o.resp);
      end
   endtask

   task automatic test_r3();
      obs_t o;
      logic [135:0] rf;
      rf = mk_r48(6'h3F, 32'h80FF_8000);
      rf[7:1] = 7'h7F;
      run_txn(6'd41, 32'd0, 2'd3, 1'b1, 2, rf, o);
      total++;
      if ({o.flags, o.ridx, o.resp[31:0]} !== {4'b0000, 6'h3F, 32'h80FF_8000}) begin
         bad++; $display("FAIL r3_nocheck: got %b %h %h want 0000 3f 80ff8000", o.flags, o.ridx, o.resp[31:0]);
      end
      rf[46] = 1'b1;
      run_txn(6'd41, 32'd0, 2'd3, 1'b1, 2, rf, o);
      total++;
      if (o.flags !== 4'b0010) begin bad++; $display("FAIL r3_txbit: got %b want 0010", o.flags); end
   endtask

   task automatic test_reset_mid();
      obs_t o, e;
      logic [135:0] rf;
      @(negedge clk_SD);
      cmd_index = 6'd55; cmd_argument = 32'hDEAD_BEEF; resp_type = 2'd1; cmd_start = 1'b1;
      @(posedge clk_SD);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk_SD);
         cmd_start = 1'b0;
      end
      total++;
      if ({busy, IO_enable_pin} !== 2'b11) begin
         bad++; $display("FAIL mid_before: got %b want 11", {busy, IO_enable_pin});
      end
      reset_host = 1'b1;
      @(negedge clk_SD);
      reset_host = 1'b0;
      total++;
      if ({busy, IO_enable_pin, CMD_PIN_OUT, cmd_complete} !== 4'b0010) begin
         bad++; $display("FAIL mid_reset: got %b want 0010", {busy, IO_enable_pin, CMD_PIN_OUT, cmd_complete});
      end
      rf = mk_r48(6'd55, 32'h0000_0900);
      run_txn(6'd55, 32'h1234_5678, 2'd1, 1'b1, 10, rf, o);
      e = ref_model(6'd55, 32'h1234_5678, 2'd1, 1'b1, 10, rf);
      total++;
      if ({o.tx, o.done_cyc, o.resp, o.flags, o.post_ok} !== {e.tx, e.done_cyc, e.resp, e.flags, e.post_ok}) begin
         bad++; $display("FAIL mid_after: got tx %h cyc %0d resp %h fl %b want tx %h cyc %0d resp %h fl %b",
                         o.tx, o.done_cyc, o.resp, o.flags, e.tx, e.done_cyc, e.resp, e.flags);
      end
   endtask

   task automatic test_random();
      obs_t o, e;
      logic [135:0] rf;
      logic [5:0]   idx, ridx;
      logic [31:0]  arg;
      logic [1:0]   rt;
      bit           respond;
      int           gap, n;
      for (int it = 0; it < 24; it++) begin
         idx = 6'($urandom); arg = $urandom; rt = 2'($urandom);
         respond = (rt != 2'd0) && ($urandom_range(0, 5) != 0);
         gap = $urandom_range(0, T - 1);
         ridx = ($urandom_range(0, 3) == 0) ? 6'($urandom) : idx;
         n = (rt == 2'd2) ? 136 : 48;
         rf = (rt == 2'd2) ? mk_r2({$urandom, $urandom, $urandom, 24'($urandom)}) : mk_r48(ridx, $urandom);
         case ($urandom_range(0, 5))
            1: rf[n-2] = ~rf[n-2];
            2: rf[n-3] = ~rf[n-3];
            3: rf[3]   = ~rf[3];
            4: rf[0]   = ~rf[0];
            5: rf[20]  = ~rf[20];
            default: ;
         endcase
         run_txn(idx, arg, rt, respond, gap, rf, o);
         e = ref_model(idx, arg, rt, respond, gap, rf);
         total++;
         if (o.tx !== e.tx) begin bad++; $display("FAIL rnd%0d_tx: got %h want %h", it, o.tx, e.tx); end
         total++;
         if ({o.done, o.done_cyc, o.send_ok, o.io_off, o.post_ok} !== {e.done, e.done_cyc, e.send_ok, e.io_off, e.post_ok}) begin
            bad++; $display("FAIL rnd%0d_timing: got done %0d cyc %0d ok %0d%0d%0d want %0d cyc %0d ok %0d%0d%0d", it,
                            o.done, o.done_cyc, o.send_ok, o.io_off, o.post_ok, e.done, e.done_cyc, e.send_ok, e.io_off, e.post_ok);
         end
         total++;
         if (o.resp !== e.resp) begin bad++; $display("FAIL rnd%0d_resp: got %h want %h", it, o.resp, e.resp); end
         total++;
         if (o.flags !== e.flags) begin bad++; $display("FAIL rnd%0d_flags: got %b want %b", it, o.flags, e.flags); end
         if (respond) begin
            total++;
            if (o.ridx !== e.ridx) begin bad++; $display("FAIL rnd%0d_ridx: got %h want %h", it, o.ridx, e.ridx); end
         end
      end
   endtask

   initial begin
      reset_host = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_argument = '0;
      resp_type = '0; CMD_PIN_IN = 1'b1;
      test_reset();
      test_cmd0();
      test_r7();
      test_r7_bad();
      test_r2();
      test_timeout();
      test_r3();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
